ram: RTL and testbench



---
 rtl/hc4_pkg.sv | 17 +
 rtl/ram_array.sv | 42 ++++
 rtl/ram.sv | 45 ++++
 tb/tb_ram.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hc4_pkg
// Description : Shared constants and types for the HC4 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package hc4_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] nibble_t;

endpackage
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_array
// Description : Flop-based storage with synchronous clear, one write port and
//               a combinational read port sharing a single address.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_array
    import hc4_pkg::*;
#(
    parameter int ADDR_W = hc4_pkg::ADDR_W,
    parameter int DATA_W = hc4_pkg::DATA_W,
    parameter int DEPTH  = hc4_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] rd_data
);

    // Flops rather than a RAM macro so that reset can clear every word.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Clear the whole array on reset (reset beats a coincident write),
    // otherwise store the bus value exactly as seen, X/Z included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

    // Read is purely combinational from the address.
    assign rd_data = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// ============================================================================
// Module      : ram
// Description : 256 x 4-bit single-port data memory on a shared bidirectional
//               bus. Writes sample the bus on the rising edge; reads drive the
//               addressed nibble onto the bus combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module ram
    import hc4_pkg::*;
#(
    parameter int ADDR_W = hc4_pkg::ADDR_W,
    parameter int DATA_W = hc4_pkg::DATA_W,
    parameter int DEPTH  = hc4_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              write_enable
);

    logic [DATA_W-1:0] w_rd_data;
    logic              w_oe;

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_addr    (address),
        .i_wr_en   (write_enable),
        .i_wr_data (data_bus),
        .rd_data   (w_rd_data)
    );

    // Drive only when out of reset and not in a write cycle; the external
    // master owns the bus during writes, and reset releases it immediately.
    assign w_oe     = rst_n & ~write_enable;
    assign data_bus = w_oe ? w_rd_data : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram
// Description : Self-checking bench for ram: vector table, scoreboard queue
//               of expected read values, and hand-written bus/reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] address;
    logic       write_enable;
    logic       tb_drv_en;
    logic [3:0] tb_data;
    wire  [3:0] data_bus;

    int checks   = 0;
    int failures = 0;

    logic [3:0] model [256];
    logic [3:0] exp_q [$];

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [3:0] data;   // write data, or expected read value
    } vec_t;

    vec_t vecs [12];

    assign data_bus = tb_drv_en ? tb_data : 4'bzzzz;

    always #5 clk = ~clk;

    ram dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_bus     (data_bus),
        .write_enable (write_enable)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One write: set up in the low phase, store at the rising edge, release.
    task automatic do_write(input logic [7:0] a, input logic [3:0] d);
        @(negedge clk);
        address      = a;
        write_enable = 1'b1;
        tb_drv_en    = 1'b1;
        tb_data      = d;
        @(posedge clk);
        #1;
        model[a]     = d;
        tb_drv_en    = 1'b0;
        write_enable = 1'b0;
    endtask

    // One read: push the expected value when driving, pop when sampling.
    task automatic do_read(input string name, input logic [7:0] a, input logic [3:0] exp);
        logic [3:0] e;
        @(negedge clk);
        address      = a;
        write_enable = 1'b0;
        tb_drv_en    = 1'b0;
        exp_q.push_back(exp);
        #2;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, data_bus, e);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        address      = 8'h00;
        write_enable = 1'b0;
        tb_drv_en    = 1'b0;
        tb_data      = 4'h0;

        vecs[0]  = '{8'h0A, 1'b1, 4'hA};
        vecs[1]  = '{8'h0A, 1'b0, 4'hA};
        vecs[2]  = '{8'h01, 1'b1, 4'h3};
        vecs[3]  = '{8'h02, 1'b1, 4'hC};
        vecs[4]  = '{8'h01, 1'b0, 4'h3};
        vecs[5]  = '{8'h02, 1'b0, 4'hC};
        vecs[6]  = '{8'hFF, 1'b1, 4'h7};
        vecs[7]  = '{8'hFF, 1'b0, 4'h7};
        vecs[8]  = '{8'h00, 1'b1, 4'h9};
        vecs[9]  = '{8'h00, 1'b0, 4'h9};
        vecs[10] = '{8'h0A, 1'b1, 4'h6};
        vecs[11] = '{8'h0A, 1'b0, 4'h6};

        // Reset for one edge, then everything reads zero.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = 4'h0;
        do_read("reset_rd_00", 8'h00, 4'h0);
        do_read("reset_rd_0A", 8'h0A, 4'h0);
        do_read("reset_rd_FF", 8'hFF, 4'h0);

        // Table-driven writes and read-backs.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data);
            else            do_read("table_rd", vecs[i].addr, vecs[i].data);
        end

        // Combinational read: address changes within one low phase, no edges.
        @(negedge clk);
        address = 8'h01;
        #1 check("async_rd_01", data_bus, 4'h3);
        address = 8'h02;
        #1 check("async_rd_02", data_bus, 4'hC);
        address = 8'h01;
        #1 check("async_rd_01b", data_bus, 4'h3);

        // Bus released during a write: 0x0A holds 4'h6, bench drives 4'h9.
        @(negedge clk);
        address      = 8'h0A;
        write_enable = 1'b1;
        tb_drv_en    = 1'b1;
        tb_data      = 4'h9;
        #1 check("wr_bus_release", data_bus, 4'h9);
        @(posedge clk);
        #1;
        model[8'h0A] = 4'h9;
        tb_drv_en    = 1'b0;
        write_enable = 1'b0;
        do_read("wr_readback_0A", 8'h0A, 4'h9);

        // Bus released in reset (0x0A holds 4'h9, bench drives 4'h6), then a
        // write coinciding with reset must lose.
        @(negedge clk);
        address   = 8'h0A;
        rst_n     = 1'b0;
        tb_drv_en = 1'b1;
        tb_data   = 4'h6;
        #1 check("rst_bus_release", data_bus, 4'h6);
        #1;
        write_enable = 1'b1;
        tb_data      = 4'hF;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        write_enable = 1'b0;
        tb_drv_en    = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 4'h0;
        do_read("rst_wins_0A", 8'h0A, model[8'h0A]);
        do_read("rst_clr_01", 8'h01, model[8'h01]);
        do_read("rst_clr_FF", 8'hFF, model[8'hFF]);

        // write_enable held across two edges rewrites the location each time.
        @(negedge clk);
        address      = 8'h33;
        write_enable = 1'b1;
        tb_drv_en    = 1'b1;
        tb_data      = 4'h2;
        @(negedge clk);
        tb_data      = 4'hD;
        @(posedge clk);
        #1;
        tb_drv_en    = 1'b0;
        write_enable = 1'b0;
        do_read("held_we_33", 8'h33, 4'hD);

        // Full sweep: write addr[3:0]^5 everywhere, then read all back.
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            av = 8'(a);
            do_write(av, av[3:0] ^ 4'h5);
        end
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            av = 8'(a);
            do_read("sweep_rd", av, model[av]);
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
